fp_add_ctrl: RTL and testbench

FP_ADD_CTRL -- requirements
Module: fp_add_ctrl

---
 rtl/fp_add_pkg.sv | 44 ++++
 rtl/fp_mant_addsub.sv | 27 ++
 rtl/fp_add_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_fp_add_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// Shared types and constants for the single-precision add/sub controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fp_add_pkg;

  localparam int SIG_W    = 27;            // hidden + 23 fraction + G + R + S
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // flag bit positions
  localparam int FLG_NV = 3;               // invalid
  localparam int FLG_OF = 2;               // overflow
  localparam int FLG_UF = 1;               // underflow
  localparam int FLG_NX = 0;               // inexact

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_UNPACK = 3'd1;
  localparam state_t ST_ALIGN  = 3'd2;
  localparam state_t ST_ADDSUB = 3'd3;
  localparam state_t ST_NORM   = 3'd4;
  localparam state_t ST_ROUND  = 3'd5;
  localparam state_t ST_DONE   = 3'd6;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } cls_e;

  // Leading-zero count of a working significand; all-zero input returns SIG_W.
  function automatic logic [4:0] lzc(input logic [SIG_W-1:0] v);
    logic [4:0] n;
    n = 5'(SIG_W);
    for (int i = 0; i < SIG_W; i++)
      if (v[i]) n = 5'(SIG_W - 1 - i);
    return n;
  endfunction

endpackage

// File: rtl/fp_mant_addsub.sv
// Combinational significand adder/subtractor with carry out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller registers the result.
module fp_mant_addsub
  import fp_add_pkg::*;
#(
  parameter int W = SIG_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] full;

  // x is always the larger magnitude, so the difference never goes negative
  // and carry can only be set by an addition.
  always_comb begin
    full = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
  end

  assign sum   = full[W-1:0];
  assign carry = full[W];

endmodule

// File: rtl/fp_add_ctrl.sv
// IEEE-754 single add/sub, multi-cycle FSM, one op in flight, RNE rounding. FP_ADD_CTRL_DENORM_EN enables subnormals (else flush-to-zero).
// Latency: out_valid 5 edges after accept; NaN/Inf/zero-zero specials 2 edges (they ride through ROUND).
// Backpressure: in_ready only in IDLE; result/flags held in DONE until out_ready, zero whenever out_valid is low.
module fp_add_ctrl
  import fp_add_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);

  localparam int FW = EXP_W + MAN_W + 1;   // packed float width
  localparam int SW = MAN_W + 4;           // working significand width
  localparam int XW = EXP_W + 2;           // exponent with overflow headroom
  localparam int RW = MAN_W + 2;           // rounded significand plus carry
`ifdef FP_ADD_CTRL_DENORM_EN
  localparam bit DENORM = 1'b1;
`else
  localparam bit DENORM = 1'b0;
`endif

  state_t        state;
  logic [FW-1:0] op_a, op_b;               // op_b carries the effective sign
  logic          sign_x, eff_sub, carry, zero_res, spec_vld;
  logic [XW-1:0] exp_x, shamt;
  logic [SW-1:0] sig_x, sig_y;
  logic [FW-1:0] spec_res;
  logic [3:0]    spec_flg;

  function automatic cls_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (&e)      return (|m) ? CLS_NAN : CLS_INF;
    else if (e == '0) return (|m) ? CLS_SUB : CLS_ZERO;
    else         return CLS_NORM;
  endfunction

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  cls_e             cls_a, cls_b;
  logic             za, zb, swap, u_sign_x, u_spec;
  logic [XW-1:0]    ua_exp, ub_exp, u_exp_x, u_exp_y, u_d;
  logic [SW-1:0]    ua_sig, ub_sig, u_sig_x, u_sig_y;
  logic [FW-1:0]    u_spec_res;
  logic [3:0]       u_spec_flg;

  assign ea = op_a[FW-2:MAN_W];
  assign ma = op_a[MAN_W-1:0];
  assign eb = op_b[FW-2:MAN_W];
  assign mb = op_b[MAN_W-1:0];

  // UNPACK: classify, expand to working significands, order by magnitude, detect specials
  always_comb begin
    cls_a  = classify(ea, ma);
    cls_b  = classify(eb, mb);
    za     = (cls_a == CLS_ZERO) || ((cls_a == CLS_SUB) && !DENORM);
    zb     = (cls_b == CLS_ZERO) || ((cls_b == CLS_SUB) && !DENORM);
    ua_sig = za ? '0 : {cls_a == CLS_NORM, ma, 3'b000};
    ub_sig = zb ? '0 : {cls_b == CLS_NORM, mb, 3'b000};
    ua_exp = za ? '0 : (cls_a == CLS_SUB) ? XW'(1) : XW'(ea);
    ub_exp = zb ? '0 : (cls_b == CLS_SUB) ? XW'(1) : XW'(eb);
    swap     = {ub_exp, ub_sig} > {ua_exp, ua_sig};
    u_sign_x = swap ? op_b[FW-1] : op_a[FW-1];
    u_exp_x  = swap ? ub_exp : ua_exp;
    u_exp_y  = swap ? ua_exp : ub_exp;
    u_sig_x  = swap ? ub_sig : ua_sig;
    u_sig_y  = swap ? ua_sig : ub_sig;
    u_d      = u_exp_x - u_exp_y;
    u_spec     = 1'b1;
    u_spec_res = '0;
    u_spec_flg = '0;
    if ((cls_a == CLS_NAN) || (cls_b == CLS_NAN) ||
        ((cls_a == CLS_INF) && (cls_b == CLS_INF) && (op_a[FW-1] != op_b[FW-1]))) begin
      u_spec_res         = FW'(QNAN);
      u_spec_flg[FLG_NV] = 1'b1;
    end else if (cls_a == CLS_INF) begin
      u_spec_res = op_a;
    end else if (cls_b == CLS_INF) begin
      u_spec_res = op_b;
    end else if (za && zb) begin
      // only (-0)+(-0) in effective terms keeps the negative sign
      u_spec_res = {op_a[FW-1] & op_b[FW-1], {(FW-1){1'b0}}};
    end else begin
      u_spec = 1'b0;
    end
  end

  logic [XW-1:0] al_sh;
  logic [SW-1:0] al_mask, al_sig;

  // ALIGN: shift Y right by min(d, SW), folding every lost bit into sticky
  always_comb begin
    al_sh   = (shamt > XW'(SW)) ? XW'(SW) : shamt;
    al_mask = ~({SW{1'b1}} << al_sh);
    al_sig  = (sig_y >> al_sh) | {{(SW-1){1'b0}}, |(sig_y & al_mask)};
  end

  logic [SW-1:0] add_sum;
  logic          add_c;

  fp_mant_addsub #(.W(SW)) u_addsub (
    .x     (sig_x),
    .y     (sig_y),
    .sub   (eff_sub),
    .sum   (add_sum),
    .carry (add_c)
  );

  logic [XW-1:0] nm_lz, nm_lim, nm_sh, nm_exp;
  logic [SW-1:0] nm_sig;

  // NORM: carry shifts right one, otherwise left by lzc but never below exponent 1
  always_comb begin
    nm_lz  = XW'(lzc(sig_x));
    nm_lim = exp_x - XW'(1);
    nm_sh  = (nm_lz > nm_lim) ? nm_lim : nm_lz;
    if (carry) begin
      nm_sig = {1'b1, sig_x[SW-1:2], sig_x[1] | sig_x[0]};
      nm_exp = exp_x + XW'(1);
    end else begin
      nm_sig = sig_x << nm_sh;
      nm_exp = exp_x - nm_sh;
    end
  end

  logic          rd_nx, rd_inc, rd_tiny, rd_hid;
  logic [RW-1:0] rd_man;
  logic [XW-1:0] rd_exp;
  logic [MAN_W-1:0] rd_frac;
  logic [FW-1:0] rd_res;
  logic [3:0]    rd_flg;

  // ROUND: nearest-even on G/R/S, then overflow / tiny / zero packing
  always_comb begin
    rd_nx   = sig_x[2] | sig_x[1] | sig_x[0];
    rd_inc  = sig_x[2] & (sig_x[1] | sig_x[0] | sig_x[3]);
    rd_man  = {1'b0, sig_x[SW-1:3]} + RW'(rd_inc);
    rd_exp  = exp_x + XW'(rd_man[RW-1]);
    rd_frac = rd_man[RW-1] ? rd_man[MAN_W:1] : rd_man[MAN_W-1:0];
    rd_hid  = rd_man[RW-1] | rd_man[MAN_W];
    rd_tiny = !sig_x[SW-1];
    rd_res  = '0;
    rd_flg  = '0;
    if (zero_res) begin
      rd_res = '0;
    end else if (!DENORM && rd_tiny) begin
      rd_res             = {sign_x, {(FW-1){1'b0}}};
      rd_flg[FLG_UF]     = 1'b1;
      rd_flg[FLG_NX]     = 1'b1;
    end else if (rd_exp >= XW'(EXP_MAX)) begin
      rd_res             = {sign_x, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rd_flg[FLG_OF]     = 1'b1;
      rd_flg[FLG_NX]     = 1'b1;
    end else begin
      // a subnormal that rounds up into the hidden bit becomes the min normal
      rd_res             = {sign_x, rd_hid ? rd_exp[EXP_W-1:0] : {EXP_W{1'b0}}, rd_frac};
      rd_flg[FLG_UF]     = DENORM && rd_tiny && rd_nx;
      rd_flg[FLG_NX]     = rd_nx;
    end
  end

  // FSM and datapath registers; reset drops any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_a     <= '0;
      op_b     <= '0;
      sign_x   <= 1'b0;
      eff_sub  <= 1'b0;
      carry    <= 1'b0;
      zero_res <= 1'b0;
      spec_vld <= 1'b0;
      exp_x    <= '0;
      shamt    <= '0;
      sig_x    <= '0;
      sig_y    <= '0;
      spec_res <= '0;
      spec_flg <= '0;
      result   <= '0;
      flags    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          op_a  <= a;
          op_b  <= {b[FW-1] ^ sub, b[FW-2:0]};
          state <= ST_UNPACK;
        end
        ST_UNPACK: begin
          sign_x   <= u_sign_x;
          exp_x    <= u_exp_x;
          sig_x    <= u_sig_x;
          sig_y    <= u_sig_y;
          shamt    <= u_d;
          eff_sub  <= op_a[FW-1] ^ op_b[FW-1];
          spec_vld <= u_spec;
          spec_res <= u_spec_res;
          spec_flg <= u_spec_flg;
          state    <= u_spec ? ST_ROUND : ST_ALIGN;
        end
        ST_ALIGN: begin
          sig_y <= al_sig;
          state <= ST_ADDSUB;
        end
        ST_ADDSUB: begin
          sig_x <= add_sum;
          carry <= add_c;
          state <= ST_NORM;
        end
        ST_NORM: begin
          sig_x    <= nm_sig;
          exp_x    <= nm_exp;
          zero_res <= !carry && (sig_x == '0);
          state    <= ST_ROUND;
        end
        ST_ROUND: begin
          result <= spec_vld ? spec_res : rd_res;
          flags  <= spec_vld ? spec_flg : rd_flg;
          state  <= ST_DONE;
        end
        ST_DONE: if (out_ready) begin
          result <= '0;
          flags  <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_fp_add_ctrl.sv
// Directed bench for fp_add_ctrl: hand-computed vectors, latency, hold and mid-op reset.
// Latency: checks 5-edge normal and 2-edge special paths.
// Backpressure: holds out_ready low in DONE for one vector.
module tb_fp_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;
  int          checks = 0;
  int          errors = 0;

  fp_add_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Issue one operation, measure latency, check output, optionally stall, then drain.
  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic vs, input logic [31:0] er, input logic [3:0] ef,
                        input int el, input int hold);
    int lat;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = va; b = vb; sub = vs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk({tag, "_busy_zero"}, result, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(el));
    chk({tag, "_result"}, result, er);
    chk({tag, "_flags"}, 32'(flags), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_result"}, result, er);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_drain_result"}, result, 32'd0);
    chk({tag, "_drain_flags"}, 32'(flags), 32'd0);
    chk({tag, "_drain_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    run_op("one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 5, 3);
    run_op("one_minus_one",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 5, 0);
    run_op("inf_minus_inf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, 2, 0);
    run_op("max_overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 5, 0);
    run_op("tie_even",       32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 5, 0);
    run_op("round_up",       32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001, 5, 0);
    run_op("three_m_one",    32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 5, 0);
    run_op("one_m_three",    32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 4'b0000, 5, 0);
    run_op("inf_plus_one",   32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 2, 0);
    run_op("ninf_sub_pinf",  32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, 2, 0);
    run_op("nan_operand",    32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 2, 0);
    run_op("neg0_plus_neg0", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 2, 0);
    run_op("pos0_sub_pos0",  32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 2, 0);
`ifdef FP_ADD_CTRL_DENORM_EN
    run_op("tiny_result",    32'h00C00000, 32'h00800000, 1'b1, 32'h00400000, 4'b0000, 5, 0);
    run_op("subnormal_in",   32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'b0001, 5, 0);
`else
    run_op("tiny_result",    32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 5, 0);
    run_op("subnormal_in",   32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'b0000, 5, 0);
`endif

    // reset pulse while the operation sits in ALIGN
    a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    chk("postrst_out_valid", 32'(out_valid), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("postrst_discarded", 32'(out_valid), 32'd0);
    run_op("after_reset",    32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000, 5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
